// File: rtl/l2_bank_arb_pkg.sv
// Shared types and bounds for the L2 bank round-robin arbiter.
package l2_bank_arb_pkg;

  localparam int MAX_MASTERS      = 8;
  localparam int MAX_RESP_LATENCY = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(MAX_MASTERS);
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } trk_entry_t;

endpackage

// File: rtl/l2_bank_arb_rr_pick.sv
// Combinational find-first-from-pointer: lowest candidate at index >= ptr,
// else lowest candidate overall (wrap).
module l2_bank_arb_rr_pick
  import l2_bank_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  excl,
  output logic [IW-1:0] win,
  output logic          any_valid
);

  logic [N-1:0] cand;

  assign cand      = req & ~excl;
  assign any_valid = |cand;

  // Second pass overrides the wrap result whenever something sits at/after ptr.
  always_comb begin
    win = '0;
    for (int i = N-1; i >= 0; i--)
      if (cand[i]) win = IW'(i);
    for (int i = N-1; i >= 0; i--)
      if (cand[i] && (i >= int'(ptr))) win = IW'(i);
  end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter time-multiplexing one L2 bank between TCDM masters.
// Optional master-0 priority with starvation guard: L2_BANK_ARB_PRIO0_EN.
module l2_bank_rr_arbiter
  import l2_bank_arb_pkg::*;
#(
  parameter int NR_MASTERS   = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LATENCY = 1,
  parameter int PRIO_MAX     = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NR_MASTERS-1:0]                    m_req_i,
  input  logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0]    m_add_i,
  input  logic [NR_MASTERS-1:0]                    m_wen_i,
  input  logic [NR_MASTERS-1:0][DATA_WIDTH-1:0]    m_wdata_i,
  input  logic [NR_MASTERS-1:0][DATA_WIDTH/8-1:0]  m_be_i,
  output logic [NR_MASTERS-1:0]                    m_gnt_o,
  output logic [NR_MASTERS-1:0]                    m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                    m_r_rdata_o,
  output logic                                     s_req_o,
  output logic [ADDR_WIDTH-1:0]                    s_add_o,
  output logic                                     s_wen_o,
  output logic [DATA_WIDTH-1:0]                    s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  s_be_o,
  input  logic                                     s_gnt_i,
  input  logic                                     s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                    s_r_rdata_i,
  output logic                                     err_o
);

  localparam int IW = idx_width(NR_MASTERS);

  if (NR_MASTERS < 2 || NR_MASTERS > MAX_MASTERS) begin : g_bad_nr
    $error("NR_MASTERS out of range");
  end
  if (RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY) begin : g_bad_lat
    $error("RESP_LATENCY out of range");
  end
  if (PRIO_MAX < 1) begin : g_bad_prio
    $error("PRIO_MAX must be at least 1");
  end

  logic [IW-1:0]         ptr, pick_win, winner;
  logic [NR_MASTERS-1:0] excl;
  logic                  pick_any, hs, routed;
  trk_entry_t            trk [RESP_LATENCY];
  trk_entry_t            last;

`ifdef L2_BANK_ARB_PRIO0_EN
  localparam int CW = $clog2(PRIO_MAX+1);
  logic [CW-1:0] prio_cnt;
  logic          others, force_rr;

  assign others   = |m_req_i[NR_MASTERS-1:1];
  assign force_rr = others && (prio_cnt == CW'(PRIO_MAX));
  assign excl     = {{(NR_MASTERS-1){1'b0}}, force_rr};
  assign winner   = (m_req_i[0] && !force_rr) ? '0 : pick_win;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) prio_cnt <= '0;
    else if (hs) begin
      if (winner != '0 || !others)       prio_cnt <= '0;
      else if (prio_cnt != CW'(PRIO_MAX)) prio_cnt <= prio_cnt + 1'b1;
    end
  end
`else
  assign excl   = '0;
  assign winner = pick_win;
`endif

  l2_bank_arb_rr_pick #(.N(NR_MASTERS), .IW(IW)) u_pick (
    .req       (m_req_i),
    .ptr       (ptr),
    .excl      (excl),
    .win       (pick_win),
    .any_valid (pick_any)
  );

  // Master 0 is only excluded while another master requests, so this is |m_req_i.
  assign s_req_o   = pick_any;
  assign hs        = s_req_o & s_gnt_i;
  assign s_add_o   = s_req_o ? m_add_i[winner]   : '0;
  assign s_wen_o   = s_req_o ? m_wen_i[winner]   : 1'b0;
  assign s_wdata_o = s_req_o ? m_wdata_i[winner] : '0;
  assign s_be_o    = s_req_o ? m_be_i[winner]    : '0;

  assign last        = trk[RESP_LATENCY-1];
  assign routed      = s_r_valid_i & last.valid;
  assign m_r_rdata_o = routed ? s_r_rdata_i : '0;

  always_comb begin
    for (int i = 0; i < NR_MASTERS; i++) begin
      m_gnt_o[i]     = hs && (winner == IW'(i));
      m_r_valid_o[i] = routed && (last.idx == idx_t'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr   <= '0;
      err_o <= 1'b0;
      for (int i = 0; i < RESP_LATENCY; i++) trk[i] <= '0;
    end else begin
      if (hs) ptr <= (winner == IW'(NR_MASTERS-1)) ? '0 : winner + 1'b1;
      trk[0].valid <= hs;
      trk[0].idx   <= idx_t'(winner);
      for (int i = 1; i < RESP_LATENCY; i++) trk[i] <= trk[i-1];
      // Stray response or a missing one: either way the bank broke the contract.
      if (s_r_valid_i != last.valid) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Directed bench: two arbiters (latency 1 and 3) share stimulus, each with a bank model.
module tb_l2_bank_rr_arbiter;

  localparam logic [31:0] ADDR [4] = '{32'h1000_0000, 32'h1000_0010, 32'h2000_0020, 32'h3000_0030};

  logic              clk = 1'b0;
  logic              rst_n, gnt, stray;
  logic [3:0]        req;
  logic [3:0][31:0]  madd, mwd;
  logic [3:0]        mwen;
  logic [3:0][3:0]   mbe;

  logic [3:0]  a_gnt, a_rv, b_gnt, b_rv;
  logic [31:0] a_rd, a_sadd, a_swd, b_rd, b_sadd, b_swd;
  logic        a_sreq, a_swen, a_err, b_sreq, b_swen, b_err;
  logic [3:0]  a_sbe, b_sbe;

  logic             b1_v = 1'b0;
  logic [31:0]      b1_d = '0;
  logic [2:0]       b3_v = '0;
  logic [2:0][31:0] b3_d = '0;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // Bank models: read data echoes the granted address; they ignore reset on purpose.
  always @(posedge clk) begin
    b1_v <= a_sreq & gnt;
    b1_d <= a_sadd;
    b3_v <= {b3_v[1:0], b_sreq & gnt};
    b3_d <= {b3_d[1:0], b_sadd};
  end

  l2_bank_rr_arbiter #(.RESP_LATENCY(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(req), .m_add_i(madd), .m_wen_i(mwen),
    .m_wdata_i(mwd), .m_be_i(mbe), .m_gnt_o(a_gnt), .m_r_valid_o(a_rv), .m_r_rdata_o(a_rd),
    .s_req_o(a_sreq), .s_add_o(a_sadd), .s_wen_o(a_swen), .s_wdata_o(a_swd), .s_be_o(a_sbe),
    .s_gnt_i(gnt), .s_r_valid_i(b1_v | stray), .s_r_rdata_i(b1_d), .err_o(a_err)
  );

  l2_bank_rr_arbiter #(.RESP_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(req), .m_add_i(madd), .m_wen_i(mwen),
    .m_wdata_i(mwd), .m_be_i(mbe), .m_gnt_o(b_gnt), .m_r_valid_o(b_rv), .m_r_rdata_o(b_rd),
    .s_req_o(b_sreq), .s_add_o(b_sadd), .s_wen_o(b_swen), .s_wdata_o(b_swd), .s_be_o(b_sbe),
    .s_gnt_i(gnt), .s_r_valid_i(b3_v[2] | stray), .s_r_rdata_i(b3_d[2]), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] t3_req [6];
    logic [31:0] t3_a   [6];
    logic [31:0] t3_b   [6];
    logic [31:0] t3_brd [6];
    logic [31:0] t6_gnt [10];
    t3_req = '{8, 1, 2, 0, 0, 0};
    t3_a   = '{0, 8, 1, 2, 0, 0};
    t3_b   = '{0, 0, 0, 8, 1, 2};
    t3_brd = '{0, 0, 0, ADDR[3], ADDR[0], ADDR[1]};
`ifdef L2_BANK_ARB_PRIO0_EN
    t6_gnt = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
`else
    t6_gnt = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`endif
    madd = {ADDR[3], ADDR[2], ADDR[1], ADDR[0]};
    mwd  = {32'hdddd_0003, 32'hdddd_0002, 32'hdddd_0001, 32'hdddd_0000};
    mwen = 4'b0101;
    mbe  = {4'hf, 4'h3, 4'hc, 4'h1};
    rst_n = 1'b0; req = '0; gnt = 1'b0; stray = 1'b0;

    // Reset state
    tick(); tick();
    #2;
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_b_err", 32'(b_err), 0);
    chk("rst_gnt",   32'(a_gnt), 0);
    chk("rst_sreq",  32'(a_sreq), 0);
    chk("rst_sadd",  a_sadd, 0);
    tick();
    rst_n = 1'b1;

    // All four request, bank always grants: rotation 0,1,2,3,0
    req = 4'hf; gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t1_gnt",  32'(a_gnt), 1 << (k % 4));
      chk("t1_sadd", a_sadd, ADDR[k % 4]);
      chk("t1_swen", 32'(a_swen), 32'(mwen[k % 4]));
      chk("t1_swd",  a_swd, 32'hdddd_0000 + (k % 4));
      if (k >= 1) begin
        chk("t1_a_rv", 32'(a_rv), 1 << ((k - 1) % 4));
        chk("t1_a_rd", a_rd, ADDR[(k - 1) % 4]);
      end else chk("t1_a_rv0", 32'(a_rv), 0);
      if (k >= 3) begin
        chk("t1_b_rv", 32'(b_rv), 1 << (k - 3));
        chk("t1_b_rd", b_rd, ADDR[k - 3]);
      end else chk("t1_b_rv0", 32'(b_rv), 0);
      tick();
    end
    req = '0;
    #2; chk("t1_a_tail", 32'(a_rv), 1); chk("t1_b_tail2", 32'(b_rv), 4); tick();
    #2; chk("t1_b_tail3", 32'(b_rv), 8); chk("t1_sreq0", 32'(a_sreq), 0); tick();
    #2; chk("t1_b_tail0", 32'(b_rv), 1); chk("t1_b_rd0", b_rd, ADDR[0]); tick();
    #2; chk("t1_a_err", 32'(a_err), 0); chk("t1_b_err", 32'(b_err), 0);

    // Stalled winner keeps priority over a newcomer
    req = 4'b0010;
    #2; chk("t2_gnt1", 32'(a_gnt), 2); tick();
    req = 4'b0100; gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t2_stall_gnt",  32'(a_gnt), 0);
      chk("t2_stall_sreq", 32'(a_sreq), 1);
      chk("t2_stall_sadd", a_sadd, ADDR[2]);
      if (k == 0) chk("t2_rv1", 32'(a_rv), 2);
      tick();
    end
    req = 4'b0110;
    #2; chk("t2_both_sadd", a_sadd, ADDR[2]); tick();
    gnt = 1'b1;
    #2; chk("t2_gnt2", 32'(a_gnt), 4); tick();
    req = 4'b0010;
    #2; chk("t2_gnt_next", 32'(a_gnt), 2); chk("t2_rv2", 32'(a_rv), 4); tick();
    req = '0;
    #2; chk("t2_rv_last", 32'(a_rv), 2); chk("t2_rd_last", a_rd, ADDR[1]);
    tick(); tick(); tick();

    // Grants 3,0,1 back to back; latency-3 responses at +3,+4,+5
    for (int c = 0; c < 6; c++) begin
      req = t3_req[c][3:0];
      #2;
      chk("t3_gnt",  32'(a_gnt), t3_req[c]);
      chk("t3_a_rv", 32'(a_rv), t3_a[c]);
      chk("t3_b_rv", 32'(b_rv), t3_b[c]);
      if (t3_b[c] != 0) chk("t3_b_rd", b_rd, t3_brd[c]);
      tick();
    end

    // Stray response sets the sticky error
    stray = 1'b1;
    #2; chk("t4_a_rv", 32'(a_rv), 0); chk("t4_b_rv", 32'(b_rv), 0); chk("t4_err_pre", 32'(a_err), 0);
    tick();
    stray = 1'b0;
    #2; chk("t4_a_err", 32'(a_err), 1); chk("t4_b_err", 32'(b_err), 1);
    tick(); tick();
    #2; chk("t4_a_sticky", 32'(a_err), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    #2; chk("t4_a_clr", 32'(a_err), 0); chk("t4_b_clr", 32'(b_err), 0);

    // Reset with two responses in flight on the latency-3 instance
    req = 4'b0001; tick();
    req = 4'b0010; tick();
    req = '0; rst_n = 1'b0;
    #2; chk("t5_a_rv_in_rst", 32'(a_rv), 2);
    tick();
    rst_n = 1'b1;
    #2; chk("t5_b_rv_drop", 32'(b_rv), 0); chk("t5_b_err_pre", 32'(b_err), 0);
    tick();
    req = 4'b1010;
    #2;
    chk("t5_b_err",  32'(b_err), 1);
    chk("t5_b_rv",   32'(b_rv), 0);
    chk("t5_a_err",  32'(a_err), 0);
    chk("t5_ptr0",   32'(a_gnt), 2);
    tick();
    req = '0; tick(); tick(); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Masters 0 and 1 request continuously
    req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      #2; chk("t6_gnt", 32'(a_gnt), t6_gnt[c]);
      tick();
    end
    req = '0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
